// File: rtl/dma_write_engine_if.sv
// rtl/dma_write_engine_if.sv - AXI4 write-channel bundle (AW/W/B) between the write DMA and memory.
interface dma_write_engine_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                      awvalid;
    logic                      awready;
    logic [ADDR_WIDTH-1:0]     awaddr;
    logic [7:0]                awlen;
    logic [2:0]                awsize;
    logic [1:0]                awburst;
    logic                      wvalid;
    logic                      wready;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   wstrb;
    logic                      wlast;
    logic                      bvalid;
    logic                      bready;
    logic [1:0]                bresp;

    modport master (
        output awvalid, awaddr, awlen, awsize, awburst,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp,
        output bready
    );

    modport slave (
        input  awvalid, awaddr, awlen, awsize, awburst,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp,
        input  bready
    );
endinterface

// File: rtl/dma_write_engine.sv
// rtl/dma_write_engine.sv - Write DMA: drains wide accelerator words into memory as AXI4 INCR bursts.
module dma_write_engine #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_LANES     = 16,
    parameter int LANE_WIDTH    = 32,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            cfg_valid_i,
    input  logic                            cfg_start_i,
    input  logic [ADDR_WIDTH-1:0]           cfg_dst_addr_i,
    input  logic [ADDR_WIDTH-1:0]           cfg_size_i,
    output logic                            cfg_ready_o,
    output logic                            cfg_done_o,
    output logic                            cfg_error_o,
    output logic [ADDR_WIDTH-1:0]           cfg_bytes_transferred_o,
    input  logic                            irq_enable_i,
    input  logic                            irq_clear_i,
    output logic                            irq_o,
    output logic                            irq_done_o,
    output logic                            irq_error_o,
    input  logic                            data_valid_i,
    output logic                            data_ready_o,
    input  logic [NUM_LANES*LANE_WIDTH-1:0] data_i,
    dma_write_engine_if.master              axi,
    output logic                            busy_o
);
    localparam int BYTES     = DATA_WIDTH / 8;
    localparam int WIDE_W    = NUM_LANES * LANE_WIDTH;
    localparam int WORDS     = WIDE_W / DATA_WIDTH;
    localparam int SIZE_LOG2 = $clog2(BYTES);
    localparam int IDX_W     = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ADDR,
        S_WR_DATA,
        S_WR_RESP,
        S_DONE,
        S_ERROR
    } state_e;

    state_e                  r_state;
    state_e                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [ADDR_WIDTH-1:0]   r_rem_beats;
    logic [ADDR_WIDTH-1:0]   r_bytes;
    logic [ADDR_WIDTH-1:0]   r_burst_bytes;
    logic [WIDE_W-1:0]       r_buf;
    logic                    r_buf_full;
    logic [IDX_W-1:0]        r_word_idx;
    logic [7:0]              r_beat_cnt;
    logic [7:0]              r_awlen;
    logic                    r_irq_done;
    logic                    r_irq_error;

    logic                    w_start;
    logic                    w_cfg_bad;
    logic [12:0]             w_page_room;
    logic [ADDR_WIDTH-1:0]   w_room_beats;
    logic [ADDR_WIDTH-1:0]   w_burst_beats;
    logic                    w_awfire;
    logic                    w_wvalid;
    logic                    w_wfire;
    logic                    w_wlast;
    logic                    w_load;
    logic                    w_bfire;
    logic                    w_in_xfer;
    logic [DATA_WIDTH-1:0]   w_words [WORDS];

    assign w_start   = cfg_valid_i & cfg_start_i;
    assign w_cfg_bad = (cfg_size_i == '0)
                    || (cfg_size_i[SIZE_LOG2-1:0] != '0)
                    || (cfg_dst_addr_i[SIZE_LOG2-1:0] != '0);

    // Beats left before the next 4KB page; addr/rem are frozen while awvalid is up.
    assign w_page_room  = 13'd4096 - {1'b0, r_addr[11:0]};
    assign w_room_beats = ADDR_WIDTH'(w_page_room >> SIZE_LOG2);

    always_comb begin
        w_burst_beats = ADDR_WIDTH'(MAX_BURST_LEN);
        if (r_rem_beats < w_burst_beats) begin
            w_burst_beats = r_rem_beats;
        end
        if (w_room_beats < w_burst_beats) begin
            w_burst_beats = w_room_beats;
        end
    end

    for (genvar g = 0; g < WORDS; g++) begin : g_words
        assign w_words[g] = r_buf[g*DATA_WIDTH +: DATA_WIDTH];
    end

    assign w_in_xfer = (r_state == S_WR_ADDR) || (r_state == S_WR_DATA) || (r_state == S_WR_RESP);
    assign w_awfire  = (r_state == S_WR_ADDR) && axi.awready;
    assign w_wvalid  = (r_state == S_WR_DATA) && r_buf_full;
    assign w_wfire   = w_wvalid && axi.wready;
    assign w_wlast   = (r_beat_cnt == r_awlen);
    assign w_bfire   = (r_state == S_WR_RESP) && axi.bvalid;
    assign w_load    = data_valid_i && data_ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = w_cfg_bad ? S_ERROR : S_WR_ADDR;
                end
            end
            S_WR_ADDR: begin
                if (axi.awready) begin
                    w_state_nxt = S_WR_DATA;
                end
            end
            S_WR_DATA: begin
                if (w_wfire && w_wlast) begin
                    w_state_nxt = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                if (axi.bvalid) begin
                    if (axi.bresp[1]) begin
                        w_state_nxt = S_ERROR;
                    end else if (r_rem_beats == '0) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_WR_ADDR;
                    end
                end
            end
            S_DONE, S_ERROR: begin
                if (!cfg_valid_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_addr        <= '0;
            r_rem_beats   <= '0;
            r_bytes       <= '0;
            r_burst_bytes <= '0;
            r_buf         <= '0;
            r_buf_full    <= 1'b0;
            r_word_idx    <= '0;
            r_beat_cnt    <= '0;
            r_awlen       <= '0;
        end else begin
            // A stale word left behind by an errored transfer must not leak into the next one.
            if ((r_state == S_IDLE) && w_start && !w_cfg_bad) begin
                r_addr      <= cfg_dst_addr_i;
                r_rem_beats <= cfg_size_i >> SIZE_LOG2;
                r_bytes     <= '0;
                r_buf_full  <= 1'b0;
                r_word_idx  <= '0;
            end
            if (w_awfire) begin
                r_awlen       <= w_burst_beats[7:0] - 8'd1;
                r_burst_bytes <= w_burst_beats << SIZE_LOG2;
                r_beat_cnt    <= '0;
            end
            if (w_load) begin
                r_buf      <= data_i;
                r_buf_full <= 1'b1;
                r_word_idx <= '0;
            end
            if (w_wfire) begin
                r_beat_cnt  <= r_beat_cnt + 8'd1;
                r_rem_beats <= r_rem_beats - ADDR_WIDTH'(1);
                r_addr      <= r_addr + ADDR_WIDTH'(BYTES);
                if ((r_word_idx == IDX_W'(WORDS - 1)) || (r_rem_beats == ADDR_WIDTH'(1))) begin
                    r_buf_full <= 1'b0;
                    r_word_idx <= '0;
                end else begin
                    r_word_idx <= r_word_idx + IDX_W'(1);
                end
            end
            if (w_bfire && !axi.bresp[1]) begin
                r_bytes <= r_bytes + r_burst_bytes;
            end
        end
    end

    // Clear outranks a same-cycle set so software never loses a clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_irq_done  <= 1'b0;
            r_irq_error <= 1'b0;
        end else if (irq_clear_i) begin
            r_irq_done  <= 1'b0;
            r_irq_error <= 1'b0;
        end else begin
            if (r_state == S_DONE) begin
                r_irq_done <= 1'b1;
            end
            if (r_state == S_ERROR) begin
                r_irq_error <= 1'b1;
            end
        end
    end

    assign cfg_ready_o             = (r_state == S_IDLE);
    assign cfg_done_o              = (r_state == S_DONE);
    assign cfg_error_o             = (r_state == S_ERROR);
    assign cfg_bytes_transferred_o = r_bytes;
    assign busy_o                  = (r_state != S_IDLE);

    assign irq_done_o  = r_irq_done & irq_enable_i;
    assign irq_error_o = r_irq_error & irq_enable_i;
    assign irq_o       = irq_done_o | irq_error_o;

    assign data_ready_o = w_in_xfer && !r_buf_full && (r_rem_beats != '0);

    assign axi.awvalid = (r_state == S_WR_ADDR);
    assign axi.awaddr  = r_addr;
    assign axi.awlen   = w_burst_beats[7:0] - 8'd1;
    assign axi.awsize  = 3'(SIZE_LOG2);
    assign axi.awburst = 2'b01;
    assign axi.wvalid  = w_wvalid;
    assign axi.wdata   = w_words[r_word_idx];
    assign axi.wstrb   = '1;
    assign axi.wlast   = w_wlast;
    assign axi.bready  = (r_state == S_WR_RESP);
endmodule

// File: tb/tb_dma_write_engine.sv
// tb/tb_dma_write_engine.sv - Randomized scoreboard bench for dma_write_engine against a burst-level reference model.
module tb_dma_write_engine;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int NL    = 16;
    localparam int LW    = 32;
    localparam int MB    = 16;
    localparam int WIDE  = NL * LW;
    localparam int WORDS = WIDE / DW;
    localparam int BYTES = DW / 8;

    localparam int P_READY  = 0;
    localparam int P_DONE   = 1;
    localparam int P_ERROR  = 2;
    localparam int P_BYTES  = 3;
    localparam int P_BUSY   = 4;
    localparam int P_AWV    = 5;
    localparam int P_WV     = 6;
    localparam int P_DREADY = 7;
    localparam int P_BREADY = 8;
    localparam int P_IRQ    = 9;
    localparam int P_QEMPTY = 10;
    localparam int P_NWORDS = 11;
    localparam int P_AWCNT  = 12;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            cfg_valid_i, cfg_start_i;
    logic [AW-1:0]   cfg_dst_addr_i, cfg_size_i;
    logic            cfg_ready_o, cfg_done_o, cfg_error_o;
    logic [AW-1:0]   cfg_bytes_transferred_o;
    logic            irq_enable_i, irq_clear_i, irq_o, irq_done_o, irq_error_o;
    logic            data_valid_i, data_ready_o;
    logic [WIDE-1:0] data_i;
    logic            busy_o;

    always #5 clk_i = ~clk_i;

    dma_write_engine_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi_if ();

    dma_write_engine #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_LANES(NL), .LANE_WIDTH(LW), .MAX_BURST_LEN(MB)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cfg_valid_i(cfg_valid_i), .cfg_start_i(cfg_start_i),
        .cfg_dst_addr_i(cfg_dst_addr_i), .cfg_size_i(cfg_size_i),
        .cfg_ready_o(cfg_ready_o), .cfg_done_o(cfg_done_o), .cfg_error_o(cfg_error_o),
        .cfg_bytes_transferred_o(cfg_bytes_transferred_o),
        .irq_enable_i(irq_enable_i), .irq_clear_i(irq_clear_i),
        .irq_o(irq_o), .irq_done_o(irq_done_o), .irq_error_o(irq_error_o),
        .data_valid_i(data_valid_i), .data_ready_o(data_ready_o), .data_i(data_i),
        .axi(axi_if), .busy_o(busy_o)
    );

    typedef struct { logic [AW-1:0] addr; logic [7:0] len; } aw_t;
    typedef struct { logic [DW-1:0] data; logic last; } w_t;
    typedef struct { int kind; logic [31:0] exp; } probe_t;

    aw_t    exp_aw[$];
    w_t     exp_w[$];
    probe_t probes[$];

    int n_checks = 0;
    int n_fail   = 0;
    int aw_hs_cnt = 0, w_hs_cnt = 0, wlast_cnt = 0, b_cnt = 0, data_hs_cnt = 0;

    int amode = 0, wmode = 0, bmode = 0, gap = 0;
    int n_words = 0, data_base = 0, aw_base = 0, err_abs = -1;
    logic [WIDE-1:0] tb_words [8];

    function automatic void check_v(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Monitor: checks every handshake against the scoreboard and services probes.
    initial begin
        aw_t aw_e;
        w_t  w_e;
        probe_t p;
        forever begin
            @(negedge clk_i);
            if (rst_ni) begin
                if (axi_if.awvalid && axi_if.awready) begin
                    check_v("aw_expected", 64'(exp_aw.size() != 0), 64'd1);
                    if (exp_aw.size() != 0) begin
                        aw_e = exp_aw.pop_front();
                        check_v("aw_addr", 64'(axi_if.awaddr), 64'(aw_e.addr));
                        check_v("aw_len", 64'(axi_if.awlen), 64'(aw_e.len));
                    end
                    check_v("aw_size_burst", 64'({axi_if.awsize, axi_if.awburst}), 64'({3'd2, 2'b01}));
                    aw_hs_cnt++;
                end
                if (axi_if.wvalid && axi_if.wready) begin
                    check_v("w_expected", 64'(exp_w.size() != 0), 64'd1);
                    if (exp_w.size() != 0) begin
                        w_e = exp_w.pop_front();
                        check_v("w_data", 64'(axi_if.wdata), 64'(w_e.data));
                        check_v("w_last", 64'(axi_if.wlast), 64'(w_e.last));
                    end
                    check_v("w_strb", 64'(axi_if.wstrb), 64'hF);
                    w_hs_cnt++;
                    if (axi_if.wlast) wlast_cnt++;
                end
                if (axi_if.bvalid && axi_if.bready) b_cnt++;
                if (data_valid_i && data_ready_o) data_hs_cnt++;
            end
            while (probes.size() != 0) begin
                p = probes.pop_front();
                case (p.kind)
                    P_READY:  check_v("cfg_ready", 64'(cfg_ready_o), 64'(p.exp));
                    P_DONE:   check_v("cfg_done", 64'(cfg_done_o), 64'(p.exp));
                    P_ERROR:  check_v("cfg_error", 64'(cfg_error_o), 64'(p.exp));
                    P_BYTES:  check_v("bytes_transferred", 64'(cfg_bytes_transferred_o), 64'(p.exp));
                    P_BUSY:   check_v("busy", 64'(busy_o), 64'(p.exp));
                    P_AWV:    check_v("awvalid", 64'(axi_if.awvalid), 64'(p.exp));
                    P_WV:     check_v("wvalid", 64'(axi_if.wvalid), 64'(p.exp));
                    P_DREADY: check_v("data_ready", 64'(data_ready_o), 64'(p.exp));
                    P_BREADY: check_v("bready", 64'(axi_if.bready), 64'(p.exp));
                    P_IRQ:    check_v("irq_o_done_err", 64'({irq_o, irq_done_o, irq_error_o}), 64'(p.exp));
                    P_QEMPTY: check_v("scoreboard_left", 64'(exp_aw.size() + exp_w.size()), 64'(p.exp));
                    P_NWORDS: check_v("wide_words_taken", 64'(data_hs_cnt - data_base), 64'(p.exp));
                    P_AWCNT:  check_v("aw_count", 64'(aw_hs_cnt - aw_base), 64'(p.exp));
                    default:  check_v("probe_kind", 64'(p.kind), 64'd0);
                endcase
            end
        end
    end

    // Memory-side and accelerator-side drivers, updated just after each rising edge.
    initial begin
        int idx, last_idx, gap_cnt;
        last_idx = -1;
        gap_cnt  = 0;
        forever begin
            @(posedge clk_i);
            #1;
            axi_if.awready = (amode != 0) ? ($urandom % 2 == 1) : 1'b1;
            axi_if.wready  = (wmode != 0) ? ($urandom % 2 == 1) : 1'b1;
            axi_if.bvalid  = (wlast_cnt > b_cnt) && ((bmode != 0) ? ($urandom % 2 == 1) : 1'b1);
            axi_if.bresp   = (b_cnt == err_abs) ? 2'b10 : 2'b00;
            idx = data_hs_cnt - data_base;
            if (idx != last_idx) begin
                gap_cnt  = 0;
                last_idx = idx;
            end
            if (idx < n_words && gap_cnt >= gap) begin
                data_valid_i = 1'b1;
                data_i       = tb_words[idx];
            end else begin
                data_valid_i = 1'b0;
                if (idx < n_words) gap_cnt++;
            end
        end
    end

    task automatic push_probe(input int kind, input logic [31:0] exp);
        probe_t p;
        p.kind = kind;
        p.exp  = exp;
        probes.push_back(p);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    // Reference model: the transfer expressed as a list of bursts and a flat beat stream.
    task automatic build_model(input longint dst, input longint size, input int err_burst, input int fill,
                               output bit bad, output bit hit, output longint bytes,
                               output int nbursts, output int nw);
        longint a, rem, room, b, k;
        aw_t aw_e;
        w_t  w_e;
        bad = (size == 0) || (size % BYTES != 0) || (dst % BYTES != 0);
        hit = 1'b0;
        bytes = 0;
        nbursts = 0;
        nw = bad ? 0 : int'(((size / BYTES) + WORDS - 1) / WORDS);
        for (int i = 0; i < 8; i++)
            for (int l = 0; l < NL; l++)
                tb_words[i][l*LW +: LW] = (fill != 0) ? (32'hA5A5_0000 | 32'(i << 8) | 32'(l)) : $urandom;
        if (bad) return;
        a = dst;
        rem = size / BYTES;
        k = 0;
        while (rem > 0 && !hit) begin
            room = (4096 - (a % 4096)) / BYTES;
            b = MB;
            if (rem < b) b = rem;
            if (room < b) b = room;
            aw_e.addr = AW'(a);
            aw_e.len  = 8'(b - 1);
            exp_aw.push_back(aw_e);
            for (longint j = 0; j < b; j++) begin
                w_e.data = tb_words[k / WORDS][(k % WORDS) * DW +: DW];
                w_e.last = (j == b - 1);
                exp_w.push_back(w_e);
                k++;
            end
            if (nbursts == err_burst) begin
                hit = 1'b1;
            end else begin
                bytes += b * BYTES;
                a += b * BYTES;
                rem -= b;
            end
            nbursts++;
        end
    endtask

    task automatic start_xfer(input longint dst, input longint size);
        @(posedge clk_i); #1;
        cfg_valid_i    = 1'b1;
        cfg_start_i    = 1'b1;
        cfg_dst_addr_i = AW'(dst);
        cfg_size_i     = AW'(size);
        @(posedge clk_i); #1;
        cfg_start_i = 1'b0;
    endtask

    task automatic run_xfer(input longint dst, input longint size, input int err_burst, input int fill);
        bit bad, hit, done_exp, err_exp;
        longint bytes;
        int nbursts, nw, t;
        build_model(dst, size, err_burst, fill, bad, hit, bytes, nbursts, nw);
        done_exp  = !bad && !hit;
        err_exp   = bad || hit;
        data_base = data_hs_cnt;
        aw_base   = aw_hs_cnt;
        err_abs   = (err_burst < 0) ? -1 : b_cnt + err_burst;
        n_words   = nw;
        start_xfer(dst, size);
        t = 0;
        while (!(cfg_done_o || cfg_error_o) && t < 5000) begin
            @(negedge clk_i);
            t++;
        end
        push_probe(P_DONE, 32'(done_exp));
        push_probe(P_ERROR, 32'(err_exp));
        push_probe(P_BYTES, 32'(bytes));
        push_probe(P_AWCNT, 32'(nbursts));
        push_probe(P_QEMPTY, 32'd0);
        push_probe(P_AWV, 32'd0);
        if (!err_exp) push_probe(P_NWORDS, 32'(nw));
        wait_cycles(2);
        @(posedge clk_i); #1;
        cfg_valid_i = 1'b0;
        n_words = 0;
        err_abs = -1;
        wait_cycles(3);
        push_probe(P_READY, 32'd1);
        push_probe(P_BUSY, 32'd0);
        push_probe(P_IRQ, {29'd0, irq_enable_i, irq_enable_i & done_exp, irq_enable_i & err_exp});
        wait_cycles(2);
        @(posedge clk_i); #1;
        irq_clear_i = 1'b1;
        @(posedge clk_i); #1;
        irq_clear_i = 1'b0;
        wait_cycles(1);
        push_probe(P_IRQ, 32'd0);
        wait_cycles(2);
    endtask

    task automatic probe_reset_state();
        push_probe(P_READY, 32'd1);
        push_probe(P_BUSY, 32'd0);
        push_probe(P_DONE, 32'd0);
        push_probe(P_ERROR, 32'd0);
        push_probe(P_AWV, 32'd0);
        push_probe(P_WV, 32'd0);
        push_probe(P_DREADY, 32'd0);
        push_probe(P_BREADY, 32'd0);
        push_probe(P_BYTES, 32'd0);
        push_probe(P_IRQ, 32'd0);
    endtask

    task automatic reset_mid_transfer();
        bit bad, hit;
        longint bytes;
        int nbursts, nw, t, w_base;
        build_model(64'h2000, 64, -1, 0, bad, hit, bytes, nbursts, nw);
        data_base = data_hs_cnt;
        n_words   = nw;
        w_base    = w_hs_cnt;
        start_xfer(64'h2000, 64);
        t = 0;
        while ((w_hs_cnt - w_base) < 4 && t < 500) begin
            @(negedge clk_i);
            t++;
        end
        @(posedge clk_i); #1;
        rst_ni = 1'b0;
        probe_reset_state();
        wait_cycles(2);
        exp_aw.delete();
        exp_w.delete();
        n_words     = 0;
        cfg_valid_i = 1'b0;
        wait_cycles(2);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        wait_cycles(2);
    endtask

    initial begin
        longint dst, size;
        int eb;
        rst_ni = 1'b0;
        cfg_valid_i = 1'b0; cfg_start_i = 1'b0; cfg_dst_addr_i = '0; cfg_size_i = '0;
        irq_enable_i = 1'b1; irq_clear_i = 1'b0;
        data_valid_i = 1'b0; data_i = '0;
        axi_if.awready = 1'b0; axi_if.wready = 1'b0; axi_if.bvalid = 1'b0; axi_if.bresp = 2'b00;
        repeat (3) @(posedge clk_i);
        #1;
        probe_reset_state();
        wait_cycles(2);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        wait_cycles(2);

        run_xfer(64'h1000, 64, -1, 1);
        run_xfer(64'h0FF8, 32, -1, 0);
        run_xfer(64'h3000, 24, -1, 0);
        wmode = 1; gap = 5;
        run_xfer(64'h4000, 128, -1, 0);
        wmode = 0; gap = 0;
        run_xfer(64'h5000, 128, 0, 0);
        run_xfer(64'h6000, 6, -1, 0);
        run_xfer(64'h1002, 16, -1, 0);
        run_xfer(64'h7000, 0, -1, 0);
        reset_mid_transfer();
        run_xfer(64'h8000, 64, -1, 0);

        for (int i = 0; i < 10; i++) begin
            amode = int'($urandom % 2);
            wmode = int'($urandom % 2);
            bmode = int'($urandom % 2);
            gap   = int'($urandom_range(0, 3));
            irq_enable_i = ($urandom % 4 != 0);
            dst = longint'($urandom_range(1, 15)) * 4096;
            if ($urandom % 2 == 1) dst += 4096 - 4 * longint'($urandom_range(1, 40));
            else dst += 4 * longint'($urandom_range(0, 1023));
            size = 4 * longint'($urandom_range(1, 64));
            eb = ($urandom % 4 == 0) ? int'($urandom_range(0, 1)) : -1;
            run_xfer(dst, size, eb, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dma_write_engine.md
Name: dma_write_engine

Overview:
- Write-direction DMA for Garuda: drains wide accelerator result words and writes them to system memory as an AXI4 write master (AW/W/B channels).
- Pairs with the read DMA engine: that engine fills accelerator buffers from memory; this block returns results to memory.
- Single descriptor per start, one outstanding burst, completion/error interrupts.

Parameters:
- DATA_WIDTH, 32, AXI data width in bits (32/64/128).
- ADDR_WIDTH, 32, address and size width.
- NUM_LANES, 16, lanes in the wide input word.
- LANE_WIDTH, 32, bits per lane.
- MAX_BURST_LEN, 16, maximum beats per AXI burst (≤256).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset
- cfg_valid_i  in  1  config qualifier
- cfg_start_i  in  1  start transfer (with cfg_valid_i)
- cfg_dst_addr_i  in  ADDR_WIDTH  destination byte address
- cfg_size_i  in  ADDR_WIDTH  transfer size in bytes
- cfg_ready_o  out  1  high in IDLE
- cfg_done_o  out  1  high in DONE
- cfg_error_o  out  1  high in ERROR
- cfg_bytes_transferred_o  out  ADDR_WIDTH  bytes acknowledged by OKAY responses
- irq_enable_i  in  1  interrupt enable
- irq_clear_i  in  1  clear interrupt status
- irq_o / irq_done_o / irq_error_o  out  1 each  interrupt outputs
- data_valid_i  in  1  wide word valid
- data_ready_o  out  1  engine can accept a wide word
- data_i  in  NUM_LANES*LANE_WIDTH  wide word from accelerator
- axi_awvalid_o  out  1 / axi_awready_i  in  1
- axi_awaddr_o  out  ADDR_WIDTH / axi_awlen_o  out  8 / axi_awsize_o  out  3 / axi_awburst_o  out  2
- axi_wvalid_o  out  1 / axi_wready_i  in  1
- axi_wdata_o  out  DATA_WIDTH / axi_wstrb_o  out  DATA_WIDTH/8 / axi_wlast_o  out  1
- axi_bvalid_i  in  1 / axi_bready_o  out  1 / axi_bresp_i  in  2
- busy_o  out  1  state != IDLE

Behaviour:
- Reset: rst_ni is asynchronous, active-low; clock is clk_i. Reset forces state IDLE, buffer empty, and all counters/IRQ flags to 0. All valid/ready/done/error/irq outputs are 0 except cfg_ready_o=1. Reset mid-transfer abandons the transfer with no further AXI activity.
- Constants:
  - BYTES=DATA_WIDTH/8; WORDS=NUM_LANES*LANE_WIDTH/DATA_WIDTH.
  - axi_awsize_o = log2(BYTES); axi_awburst_o=2'b01 (INCR); axi_wstrb_o all ones.
- States: IDLE, WR_ADDR, WR_DATA, WR_RESP, DONE, ERROR.
- IDLE:
  - Start is cfg_valid_i&cfg_start_i; it is ignored in any other state.
  - On start, if size==0, size%BYTES!=0 or dst%BYTES!=0 -> ERROR, with no AXI traffic.
  - Otherwise latch addr and rem_beats=size/BYTES, clear bytes_transferred, go WR_ADDR.
- Burst sizing (computed when entering WR_ADDR, held stable while awvalid):
  - beats = min(MAX_BURST_LEN, rem_beats, (4096 - addr[11:0])/BYTES); a burst never crosses a 4KB boundary.
  - awlen = beats-1.
- WR_ADDR: awvalid=1 until awready; then go WR_DATA with beat counter = 0.
- WR_DATA:
  - wvalid=1 only while the wide buffer holds data.
  - wdata = buffer slice [word_idx*DATA_WIDTH +: DATA_WIDTH], sent LSB word first.
  - wlast=1 on beat counter == awlen.
  - On each wvalid&wready: word_idx++, rem_beats--, addr+=BYTES.
  - Buffer empties when word_idx reaches WORDS or rem_beats reaches 0; unused words of a partial final buffer are discarded.
  - After the wlast handshake go WR_RESP.
- Input side:
  - data_ready_o = (state in WR_ADDR/WR_DATA/WR_RESP) && buffer empty && rem_beats != 0.
  - A handshake loads the buffer at the clock edge, word_idx=0. Earliest wvalid is the cycle after load.
  - A wide word may straddle bursts; word_idx persists across bursts.
- WR_RESP:
  - bready=1.
  - On bvalid with bresp[1]==0: bytes_transferred += beats*BYTES; go DONE if rem_beats==0, else WR_ADDR.
  - bresp[1]==1 (SLVERR/DECERR) -> ERROR without adding bytes.
- DONE/ERROR: cfg_done_o / cfg_error_o high; return to IDLE when cfg_valid_i==0 (at least one cycle spent in each).
- Interrupts:
  - irq_done_q sets on the cycle state is DONE; irq_error_q likewise for ERROR.
  - irq_clear_i clears both and wins over a same-cycle set.
  - irq_done_o = irq_done_q&irq_enable_i; irq_error_o likewise; irq_o = OR of the two.
- Arithmetic: all address/size math is ADDR_WIDTH unsigned; the 4KB term uses 13-bit math (4096 max).

Test Plan:
- dst=0x1000, size=64, one data_i word of 16 distinct 32b values, ready always high -> one AW (addr 0x1000, awlen=15, awsize=2); 16 W beats in lane order with wlast on 16th; bresp OKAY -> cfg_done_o, bytes_transferred=64, irq_done_o=1 with enable; irq_clear_i -> 0.
- dst=0x0FF8, size=32 -> AW 0x0FF8 awlen=1, then AW 0x1000 awlen=5; 8 beats total from one wide word; bytes_transferred=32.
- size=24 -> awlen=5, 6 beats; words 6..15 discarded; data_ready_o low after the load; DONE.
- size=128 with wready toggling 50% and a 5-cycle gap before the second data_valid_i -> wvalid drops while the buffer is empty; 32 beats in exact order, none lost or duplicated; two bursts.
- size=128, first bresp=2'b10 -> ERROR, cfg_error_o=1, bytes_transferred=0, irq_error_o=1, no second AW. size=6 or dst=0x1002 -> ERROR with awvalid never asserted.
- rst_ni low mid-WR_DATA -> outputs immediately at reset values, busy_o=0; a new start after reset completes normally.
